// File: rtl/clk_sequencer.sv
// clk_sequencer: RUN/PAUSE/ADJ sequencer driving mm:ss counter strobes and display blank flags.
// Define CLK_SEQ_DEBOUNCE_EN to insert a counter-based debouncer on the pause button.
module clk_sequencer #(
    parameter int DB_W            = 20,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_1hz,
    input  logic tick_adj,
    input  logic btn_pause,
    input  logic sw_adj,
    input  logic sw_sel,
    input  logic sw_dir,
    output logic secselect,
    output logic minselect,
    output logic isdec,
    output logic paused,
    output logic adj_mode,
    output logic sec_blank,
    output logic min_blank
);
    typedef enum logic [1:0] {RUN, PAUSE, ADJ} state_t;

    state_t     state_q, state_d;
    logic [1:0] sync_q, sync_d;
    logic       prev_q, prev_d, lvl, press, run_tick, adj_tick;
    logic       phase_q, phase_d;
    logic       sec_q, sec_d, min_q, min_d, dec_q, dec_d;
    logic       paused_q, paused_d, adj_q, adj_d, sb_q, sb_d, mb_q, mb_d;

`ifdef CLK_SEQ_DEBOUNCE_EN
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    logic            acc_q, acc_d;
    logic [DB_W-1:0] cnt_q, cnt_d;

    always_comb begin
        acc_d = acc_q;
        cnt_d = '0;
        if (sync_q[1] != acc_q) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == DB_LAST) begin
                acc_d = ~acc_q;
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign lvl = acc_q;
`else
    // Keeps the debounce parameters referenced when the debouncer is compiled out
    logic [DB_W-1:0] db_unused;
    assign db_unused = DB_W'(DEBOUNCE_CYCLES);
    assign lvl = sync_q[1];
`endif

    always_comb begin
        sync_d   = {sync_q[0], btn_pause};
        prev_d   = lvl;
        press    = lvl & ~prev_q;
        state_d  = sw_adj                         ? ADJ   :
                   (state_q == ADJ)               ? PAUSE :
                   (press && state_q == RUN)      ? PAUSE :
                   (press && state_q == PAUSE)    ? RUN   : state_q;
        // Strobes follow the pre-transition state
        run_tick = (state_q == RUN) & tick_1hz;
        adj_tick = (state_q == ADJ) & tick_adj;
        sec_d    = run_tick | (adj_tick & ~sw_sel);
        min_d    = run_tick | (adj_tick & sw_sel);
        dec_d    = adj_tick & sw_dir;
        phase_d  = (state_d == ADJ && state_q != ADJ) ? 1'b1 :
                   (state_q == ADJ && tick_1hz)       ? ~phase_q : phase_q;
        paused_d = (state_d == PAUSE);
        adj_d    = (state_d == ADJ);
        sb_d     = adj_d & ~sw_sel & ~phase_d;
        mb_d     = adj_d & sw_sel & ~phase_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RUN;
            sync_q   <= '0;
            prev_q   <= 1'b0;
            phase_q  <= 1'b1;
            sec_q    <= 1'b0;
            min_q    <= 1'b0;
            dec_q    <= 1'b0;
            paused_q <= 1'b0;
            adj_q    <= 1'b0;
            sb_q     <= 1'b0;
            mb_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            prev_q   <= prev_d;
            phase_q  <= phase_d;
            sec_q    <= sec_d;
            min_q    <= min_d;
            dec_q    <= dec_d;
            paused_q <= paused_d;
            adj_q    <= adj_d;
            sb_q     <= sb_d;
            mb_q     <= mb_d;
        end
    end

    assign secselect = sec_q;
    assign minselect = min_q;
    assign isdec     = dec_q;
    assign paused    = paused_q;
    assign adj_mode  = adj_q;
    assign sec_blank = sb_q;
    assign min_blank = mb_q;
endmodule

// File: tb/tb_clk_sequencer.sv
// tb_clk_sequencer: directed checks of clk_sequencer strobes, state flags and blanking.
module tb_clk_sequencer;
`ifdef CLK_SEQ_DEBOUNCE_EN
    localparam int BTN_LAT = 11;
`else
    localparam int BTN_LAT = 3;
`endif

    logic clk = 1'b0, reset = 1'b1;
    logic tick_1hz = 1'b0, tick_adj = 1'b0, btn_pause = 1'b0;
    logic sw_adj = 1'b0, sw_sel = 1'b0, sw_dir = 1'b0;
    logic secselect, minselect, isdec, paused, adj_mode, sec_blank, min_blank;
    logic [6:0] outs;
    int checks = 0, errors = 0;

    clk_sequencer #(.DB_W(4), .DEBOUNCE_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .tick_adj(tick_adj),
        .btn_pause(btn_pause), .sw_adj(sw_adj), .sw_sel(sw_sel), .sw_dir(sw_dir),
        .secselect(secselect), .minselect(minselect), .isdec(isdec), .paused(paused),
        .adj_mode(adj_mode), .sec_blank(sec_blank), .min_blank(min_blank)
    );

    always #5 clk = ~clk;

    // {secselect, minselect, isdec, paused, adj_mode, sec_blank, min_blank}
    assign outs = {secselect, minselect, isdec, paused, adj_mode, sec_blank, min_blank};

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic btn_cycle();
        btn_pause = 1'b1;
        repeat (BTN_LAT + 2) step();
        btn_pause = 1'b0;
        repeat (BTN_LAT + 4) step();
    endtask

    initial begin
        repeat (2) step();
        check("in_reset", outs, 7'b0000000);
        reset = 1'b0;
        step();
        check("after_reset", outs, 7'b0000000);

        for (int i = 0; i < 3; i++) begin
            tick_1hz = 1'b1;
            step();
            tick_1hz = 1'b0;
            check("run_strobe", outs, 7'b1100000);
            step();
            check("run_gap", outs, 7'b0000000);
        end

        btn_pause = 1'b1;
        repeat (BTN_LAT - 1) step();
        check("pause_not_yet", outs, 7'b0000000);
        step();
        check("pause_enter", outs, 7'b0001000);
        repeat (7) step();
        btn_pause = 1'b0;
        repeat (BTN_LAT + 4) step();
        check("pause_hold", outs, 7'b0001000);
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        check("pause_no_strobe", outs, 7'b0001000);
        step();
        check("pause_no_strobe2", outs, 7'b0001000);

        btn_pause = 1'b1;
        repeat (BTN_LAT) step();
        check("resume_run", outs, 7'b0000000);
        repeat (2) step();
        btn_pause = 1'b0;
        repeat (BTN_LAT + 4) step();
        check("run_hold", outs, 7'b0000000);

        sw_adj = 1'b1; sw_sel = 1'b1; sw_dir = 1'b1;
        step();
        check("adj_enter", outs, 7'b0000100);
        for (int i = 0; i < 4; i++) begin
            tick_adj = 1'b1;
            step();
            tick_adj = 1'b0;
            check("adj_min_down", outs, 7'b0110100);
            step();
            check("adj_gap", outs, 7'b0000100);
        end
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        check("min_blank_on", outs, 7'b0000101);
        step();
        check("min_blank_hold", outs, 7'b0000101);
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        check("min_blank_off", outs, 7'b0000100);

        sw_sel = 1'b0; sw_dir = 1'b0; tick_adj = 1'b1;
        step();
        tick_adj = 1'b0;
        check("adj_sec_up", outs, 7'b1000100);
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        check("sec_blank_on", outs, 7'b0000110);
        btn_pause = 1'b1;
        repeat (BTN_LAT + 2) step();
        btn_pause = 1'b0;
        repeat (BTN_LAT + 4) step();
        check("adj_ignores_press", outs, 7'b0000110);

        sw_adj = 1'b0;
        step();
        check("adj_exit_pause", outs, 7'b0001000);
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        check("exit_no_strobe", outs, 7'b0001000);

        sw_adj = 1'b1; sw_sel = 1'b1; tick_adj = 1'b1;
        step();
        tick_adj = 1'b0;
        check("adj_entry_tick", outs, 7'b0000100);
        sw_adj = 1'b0;
        step();
        check("back_pause", outs, 7'b0001000);

        btn_cycle();
        check("run_again", outs, 7'b0000000);

        btn_pause = 1'b1;
        repeat (BTN_LAT - 1) step();
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        check("tick_with_press", outs, 7'b1101000);
        step();
        check("then_paused", outs, 7'b0001000);
        repeat (2) step();
        btn_pause = 1'b0;
        repeat (BTN_LAT + 4) step();
        btn_cycle();
        check("run_for_reset", outs, 7'b0000000);

`ifdef CLK_SEQ_DEBOUNCE_EN
        for (int i = 0; i < 3; i++) begin
            btn_pause = 1'b1;
            repeat (5) step();
            btn_pause = 1'b0;
            repeat (6) step();
            check("glitch_ignored", outs, 7'b0000000);
        end
`endif

        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        check("pre_reset_strobe", outs, 7'b1100000);
        #2 reset = 1'b1;
        #1 check("async_reset", outs, 7'b0000000);
        step();
        reset = 1'b0;
        step();
        check("post_reset", outs, 7'b0000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/clk_sequencer.md
# clk_sequencer

Control sequencer for the mm:ss counter datapath. It turns a 1 Hz run tick, an adjust-rate tick and the front-panel pause button and switches into the one-cycle `secselect` / `minselect` / `isdec` strobes that drive the counter. It also produces pause/adjust status and field-blank flags for the display driver. The block sits between the tick dividers and the counter, and is the only source of counter strobes.

## Interface
Parameters:
- `DB_W`, default 20: width of the debounce counter. Used only when debounce is compiled in.
- `DEBOUNCE_CYCLES`, default 500000: number of consecutive stable cycles required before a button level is accepted (10 ms at 50 MHz).

Ports:
- `clk` input, 1: system clock; all state updates on its rising edge.
- `reset` input, 1: asynchronous, active-high; returns the block to RUN.
- `tick_1hz` input, 1: one-cycle pulse once per second.
- `tick_adj` input, 1: one-cycle pulse at the adjust repeat rate.
- `btn_pause` input, 1: raw, asynchronous pause/resume button.
- `sw_adj` input, 1: adjust-mode switch; level-sensitive, already synchronous.
- `sw_sel` input, 1: adjust target; 0 = seconds, 1 = minutes.
- `sw_dir` input, 1: adjust direction; 0 = up, 1 = down.
- `secselect` output, 1: seconds-step strobe to the counter.
- `minselect` output, 1: minutes-step strobe to the counter.
- `isdec` output, 1: decrement qualifier, valid with the strobes.
- `paused` output, 1: high in PAUSE.
- `adj_mode` output, 1: high in ADJ.
- `sec_blank` output, 1: blank the seconds digits.
- `min_blank` output, 1: blank the minutes digits.

## Operation
- States: RUN, PAUSE, ADJ. Reset state is RUN.
- Button path:
  - `btn_pause` passes through a 2-flop synchroniser, then the optional debouncer, then a rising-edge detector.
  - The detector output `press` is a one-cycle pulse.
- Transitions, in priority order:
  1. From any state, `sw_adj`=1 moves to ADJ.
  2. In ADJ, `sw_adj`=0 moves to PAUSE.
  3. In RUN, `press` moves to PAUSE.
  4. In PAUSE, `press` moves to RUN.
  5. Otherwise the state holds.
- `press` is ignored in ADJ.
- Strobe generation uses the current (registered) state:
  - RUN and `tick_1hz`: `secselect`=1, `minselect`=1, `isdec`=0. The counter carries minutes at :59 itself.
  - ADJ and `tick_adj`, `sw_sel`=0: `secselect`=1, `minselect`=0, `isdec`=`sw_dir`.
  - ADJ and `tick_adj`, `sw_sel`=1: `secselect`=0, `minselect`=1, `isdec`=`sw_dir`.
  - All other cycles: all three strobes are 0.
  - No strobe is ever asserted in PAUSE.
  - `secselect`=`minselect`=`isdec`=1 is never generated.
- Blink phase bit:
  - Set to 1 on entry to ADJ.
  - Toggles on each `tick_1hz` while in ADJ.
- Blanking:
  - `sec_blank` = `adj_mode` & ~`sw_sel` & ~phase.
  - `min_blank` = `adj_mode` & `sw_sel` & ~phase.
  - Both flags are 0 outside ADJ.

## Timing
- All outputs are registered.
- Reset values: `secselect`, `minselect`, `isdec`, `paused`, `adj_mode`, `sec_blank`, `min_blank` are all 0. State = RUN; blink phase = 1; synchroniser, edge and debounce registers = 0.
- Strobe latency: a tick sampled high at edge N gives outputs high for exactly the cycle after edge N, and low after edge N+1.
- Button latency without debounce:
  - `btn_pause` rising before edge 1 → synchroniser at edges 1–2 → state changes at edge 3.
  - `paused` changes at that same edge.
- With debounce, add `DEBOUNCE_CYCLES` cycles to the button latency.
- Tick coincident with a state change: the strobe follows the pre-transition state.
  - Example: `tick_1hz` and `press` in the same cycle in RUN gives one run strobe, then PAUSE.
- Entering ADJ coincident with `tick_adj`: no adjust strobe in that cycle.
- `sw_sel` and `sw_dir` are sampled in the cycle `tick_adj` is high.
- Reset asserted mid-strobe clears the strobes immediately (asynchronously). No partial pulse persists after reset release.

## Configuration
- `CLK_SEQ_DEBOUNCE_EN` defined:
  - A `DB_W`-bit counter increments while the synchronised level differs from the accepted level, and clears otherwise.
  - When the count reaches `DEBOUNCE_CYCLES`-1, the accepted level flips and the counter clears.
  - Edge detection acts on the accepted level.
- Not defined:
  - The debounce logic is absent and `DB_W` / `DEBOUNCE_CYCLES` are unused.
  - Edge detection acts directly on the synchroniser output.

## Test plan
- Reset release, then `tick_1hz` pulsed 3 times → 3 single-cycle strobes with `secselect`=`minselect`=1, `isdec`=0, each one cycle after its tick; `paused`=0.
- `btn_pause` held high 10 cycles, macro undefined → `paused`=1 at the 3rd edge. Further ticks produce no strobes. A second press returns to RUN.
- `sw_adj`=1, `sw_sel`=1, `sw_dir`=1, 4 `tick_adj` pulses → 4 strobes with `minselect`=1, `secselect`=0, `isdec`=1. `min_blank` toggles with `tick_1hz`; `sec_blank`=0.
- `sw_adj` 1→0 → state is PAUSE (`paused`=1, `adj_mode`=0, both blanks 0). `tick_1hz` gives no strobe.
- `CLK_SEQ_DEBOUNCE_EN` defined, `DEBOUNCE_CYCLES`=8:
  - 5-cycle glitches on `btn_pause` → no state change.
  - A 12-cycle press → PAUSE 11 cycles after the rise.
- `tick_1hz` and `press` in the same cycle in RUN → one strobe, then `paused`=1. Asserting `reset` mid-strobe clears all outputs at once.
